// File: rtl/gate_truth_checker.sv
// gate_truth_checker: exhaustive truth-table sweep and check of a small combinational gate.
// Ports: clk, clrn (sync active-low reset), start (begin sweep in IDLE/DONE), dut_f (gate output);
//        vec (gate inputs), busy, done, pass, err_cnt, first_err_vec, first_err_valid.
// Each vector is held SETTLE+1 cycles and dut_f is compared on the last one.
module gate_truth_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2,
    parameter int OP     = 0
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            start,
    input  logic            dut_f,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [7:0]      SETTLE_C = 8'(SETTLE);
    localparam logic [N_IN-1:0] VEC_MAX  = '1;
    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d, fev_q, fev_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [N_IN:0]   err_q, err_d;
    logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d, fevld_q, fevld_d;
    logic            exp_f;
    // OP values outside 1..4 fall back to NOR
    always_comb exp_f = (OP == 1) ? ~&vec_q :
                        (OP == 2) ?  |vec_q :
                        (OP == 3) ?  &vec_q :
                        (OP == 4) ?  ^vec_q : ~|vec_q;
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        fev_d   = fev_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fevld_d = fevld_q;
        if (state_q != RUN) begin
            if (start) begin
                state_d = RUN;
                vec_d   = '0;
                cnt_d   = '0;
                err_d   = '0;
                fevld_d = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
                busy_d  = 1'b1;
            end
        end else if (cnt_q != SETTLE_C) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            if (dut_f != exp_f) begin
                err_d = err_q + 1'b1;
                fev_d   = fevld_q ? fev_q : vec_q;
                fevld_d = 1'b1;
            end
            if (vec_q == VEC_MAX) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_d == '0);
            end else begin
                vec_d = vec_q + 1'b1;
                cnt_d = '0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= IDLE;
            vec_q   <= '0;
            fev_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fevld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            fev_q   <= fev_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fevld_q <= fevld_d;
        end
    end
    assign vec             = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fevld_q;
endmodule
